// File: rtl/popcount_sched_pkg.sv
// Shared types and helpers for the time-multiplexed popcount scheduler.
package popcount_sched_pkg;

  // Width of one chunk, which is also the number of inputs to the shared adder tree
  localparam int TREE_W     = 64;
  // Width of the adder-tree count (0..64)
  localparam int TREE_CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result width able to hold the count of every bit in a CHUNKS-chunk vector
  function automatic int sum_width(input int chunks);
    return $clog2(TREE_W * chunks + 1);
  endfunction

endpackage

// File: rtl/popcount_sched_adder_tree.sv
// adder_tree_64: combinational population count of one 64-bit chunk,
// built as a balanced binary tree of pairwise adders.
module adder_tree_64
  import popcount_sched_pkg::*;
(
  input  logic [TREE_W-1:0]     data,
  output logic [TREE_CNT_W-1:0] count
);

  logic [1:0] l1_s [32];
  logic [2:0] l2_s [16];
  logic [3:0] l3_s [8];
  logic [4:0] l4_s [4];
  logic [5:0] l5_s [2];

  // Pairwise reduction, each level one bit wider than the one below
  always_comb begin
    for (int i = 0; i < 32; i++) l1_s[i] = {1'b0, data[2*i]} + {1'b0, data[2*i+1]};
    for (int i = 0; i < 16; i++) l2_s[i] = {1'b0, l1_s[2*i]} + {1'b0, l1_s[2*i+1]};
    for (int i = 0; i < 8; i++)  l3_s[i] = {1'b0, l2_s[2*i]} + {1'b0, l2_s[2*i+1]};
    for (int i = 0; i < 4; i++)  l4_s[i] = {1'b0, l3_s[2*i]} + {1'b0, l3_s[2*i+1]};
    for (int i = 0; i < 2; i++)  l5_s[i] = {1'b0, l4_s[2*i]} + {1'b0, l4_s[2*i+1]};
    count = {1'b0, l5_s[0]} + {1'b0, l5_s[1]};
  end

endmodule

// File: rtl/popcount_sched.sv
// popcount_sched: counts the ones in a CHUNKS x 64-bit vector by walking one
// shared 64-input adder tree over the chunks, one chunk per cycle.
// Optional build macro POPCOUNT_SCHED_THRESH_EN adds input thresh and the
// registered comparison output above (result > thresh).
module popcount_sched
  import popcount_sched_pkg::*;
#(
  parameter  int CHUNKS = 4,
  localparam int SUM_W  = sum_width(CHUNKS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TREE_W*CHUNKS-1:0] in_bits,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         sum
`ifdef POPCOUNT_SCHED_THRESH_EN
  ,
  input  logic [SUM_W-1:0]         thresh,
  output logic                     above
`endif
);

  localparam int IDX_W = $clog2(CHUNKS);

  state_t                    state_r;
  logic [IDX_W-1:0]          idx_r;
  logic [SUM_W-1:0]          acc_r;
  logic [SUM_W-1:0]          acc_next_s;
  logic [SUM_W-1:0]          sum_r;
  logic                      out_valid_r;
  logic [TREE_W*CHUNKS-1:0]  vec_r;
  logic [TREE_W-1:0]         chunk_s;
  logic [TREE_CNT_W-1:0]     cnt_s;
  logic                      in_ready_s;
  logic                      xfer_s;
  logic                      last_s;
`ifdef POPCOUNT_SCHED_THRESH_EN
  logic                      above_r;
`endif

  // Accept in idle, or in done only when the held result drains on the same edge
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      DONE:    in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign xfer_s = in_valid & in_ready_s;

  // Select the chunk addressed by the running index and form the next accumulator value
  always_comb begin
    chunk_s    = vec_r[int'(idx_r)*TREE_W +: TREE_W];
    acc_next_s = acc_r + SUM_W'(cnt_s);
    last_s     = (idx_r == IDX_W'(CHUNKS - 1));
  end

  adder_tree_64 u_tree (
    .data  (chunk_s),
    .count (cnt_s)
  );

  // Capture the vector on an accepting edge; contents are don't-care until then
  always_ff @(posedge CLK) begin
    if (xfer_s) begin
      vec_r <= in_bits;
    end
  end

  // Scheduler FSM with registered result, valid and optional threshold flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      acc_r       <= '0;
      sum_r       <= '0;
      out_valid_r <= 1'b0;
`ifdef POPCOUNT_SCHED_THRESH_EN
      above_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            state_r <= ACCUM;
            idx_r   <= '0;
            acc_r   <= '0;
          end
        end
        ACCUM: begin
          acc_r <= acc_next_s;
          if (last_s) begin
            state_r     <= DONE;
            idx_r       <= '0;
            sum_r       <= acc_next_s;
            out_valid_r <= 1'b1;
`ifdef POPCOUNT_SCHED_THRESH_EN
            above_r     <= (acc_next_s > thresh);
`endif
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (in_valid) begin
              state_r <= ACCUM;
              idx_r   <= '0;
              acc_r   <= '0;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          acc_r       <= '0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
`ifdef POPCOUNT_SCHED_THRESH_EN
  assign above     = above_r;
`endif

endmodule

// File: tb/tb_popcount_sched.sv
// Bench for popcount_sched at CHUNKS=4 using a result scoreboard queue.
// Build with POPCOUNT_SCHED_THRESH_EN defined to also exercise thresh/above.
module tb_popcount_sched;

  localparam int CHUNKS = 4;
  localparam int W      = 64 * CHUNKS;
  localparam int SUM_W  = $clog2(W + 1);

  logic             CLK = 1'b0;
  logic             nRST;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum;
`ifdef POPCOUNT_SCHED_THRESH_EN
  logic [SUM_W-1:0] thresh;
  logic             above;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];

  popcount_sched #(.CHUNKS(CHUNKS)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef POPCOUNT_SCHED_THRESH_EN
    ,
    .thresh    (thresh),
    .above     (above)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Present v at the current negedge, accepted at the next posedge; then scramble in_bits
  task automatic accept(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_bits  = v;
    sb_q.push_back($countones(v));
    @(negedge CLK);
    in_valid = 1'b0;
    in_bits  = rand_vec();
  endtask

  // Count negedges until out_valid, bounded
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bits = '0;
`ifdef POPCOUNT_SCHED_THRESH_EN
    thresh = '0;
`endif
    repeat (3) @(negedge CLK);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %0d want 0", sum); end
`ifdef POPCOUNT_SCHED_THRESH_EN
    n_checks++; if (above !== 1'b0) begin n_fail++; $display("FAIL reset_above: got %b want 0", above); end
`endif
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_all_ones();
    int lat, exp;
    out_ready = 1'b1;
    accept({W{1'b1}});
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ones_ready_accum: got %b want 0", in_ready); end
    wait_out(lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ones_latency: got %0d want 4", lat); end
    exp = sb_q.pop_front();
    n_checks++; if (sum !== SUM_W'(exp)) begin n_fail++; $display("FAIL ones_sum: got %0d want %0d", sum, exp); end
    @(negedge CLK);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ones_drain: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_mixed();
    int lat, exp;
    out_ready = 1'b1;
    accept({64'h0, 64'hFFFF, 64'h1, 64'h8000_0000_0000_0000});
    wait_out(lat);
    exp = sb_q.pop_front();
    n_checks++; if (sum !== SUM_W'(exp) || exp != 18) begin n_fail++; $display("FAIL mixed_sum: got %0d want %0d", sum, exp); end
    @(negedge CLK);
  endtask

  task automatic test_random();
    int lat, exp;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      accept(rand_vec());
      wait_out(lat);
      n_checks++; if (lat != 4) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 4", k, lat); end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      exp = sb_q.pop_front();
      n_checks++; if (sum !== SUM_W'(exp)) begin n_fail++; $display("FAIL rand_sum[%0d]: got %0d want %0d", k, sum, exp); end
      out_ready = 1'b1;
      @(negedge CLK);
    end
  endtask

  task automatic test_backpressure();
    int lat, exp;
    logic [SUM_W-1:0] held;
    bit bad;
    out_ready = 1'b0;
    accept(rand_vec());
    wait_out(lat);
    exp  = sb_q.pop_front();
    held = sum;
    n_checks++; if (sum !== SUM_W'(exp)) begin n_fail++; $display("FAIL bp_sum: got %0d want %0d", sum, exp); end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (out_valid !== 1'b1 || sum !== held || in_ready !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL bp_hold: got valid=%b sum=%0d ready=%b want 1/%0d/0", out_valid, sum, in_ready, held); end
    out_ready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL bp_single_transfer: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int lat, exp;
    out_ready = 1'b1;
    accept({W{1'b0}});
    wait_out(lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 4", lat); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_done: got %b want 1", in_ready); end
    exp = sb_q.pop_front();
    n_checks++; if (sum !== SUM_W'(exp)) begin n_fail++; $display("FAIL b2b_sum0: got %0d want %0d", sum, exp); end
    accept({W{1'b1}});
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_direct_accum: got valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    wait_out(lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", lat); end
    exp = sb_q.pop_front();
    n_checks++; if (sum !== SUM_W'(exp)) begin n_fail++; $display("FAIL b2b_sum1: got %0d want %0d", sum, exp); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int lat, exp;
    bit bad;
    out_ready = 1'b1;
    accept({W{1'b1}});
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_async: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    void'(sb_q.pop_front());
    @(negedge CLK);
    nRST = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL rst_mid_discard: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    accept({(W/8){8'h55}});
    wait_out(lat);
    exp = sb_q.pop_front();
    n_checks++; if (sum !== SUM_W'(exp) || exp != 128) begin n_fail++; $display("FAIL rst_mid_next_sum: got %0d want %0d", sum, exp); end
    @(negedge CLK);
  endtask

`ifdef POPCOUNT_SCHED_THRESH_EN
  task automatic test_thresh();
    int lat, exp;
    logic [W-1:0] v;
    out_ready = 1'b1;
    thresh = SUM_W'(128);
    for (int n = 129; n >= 128; n--) begin
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      accept(v);
      wait_out(lat);
      exp = sb_q.pop_front();
      n_checks++; if (sum !== SUM_W'(exp)) begin n_fail++; $display("FAIL thresh_sum[%0d]: got %0d want %0d", n, sum, exp); end
      n_checks++; if (above !== (exp > 128)) begin n_fail++; $display("FAIL thresh_above[%0d]: got %b want %b", n, above, (exp > 128)); end
      @(negedge CLK);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_ones();
    test_mixed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef POPCOUNT_SCHED_THRESH_EN
    test_thresh();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
